// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - CPU execution sequencer: run / single-step / input-stall clock enable
//
// Produces a one-cycle cpu_en tick that advances the CPU core, replacing a
// fixed divided clock. Modes: HALT, RUN (one tick every 2^DIV_W cycles),
// STEP (one tick per debounced step press) and WAIT_IN (stalled on an IN
// instruction until the operator confirms with the ready button).
//
// Ports:
//   clk        system clock, the only clock used
//   n_reset    asynchronous active-low reset
//   run_sw     raw run switch, 1 = RUN, 0 = HALT
//   step_btn   raw single-step button, active-high
//   ready_btn  raw input-confirm button, active-high
//   in_req     CPU is executing IN and needs data
//   cpu_en     single-cycle advance tick to the CPU
//   ready_out  input data confirmed, to the CPU's ready_in
//   mode       HALT=0, RUN=1, STEP=2, WAIT_IN=3
//   in_wait    high in WAIT_IN (LED)

module cpu_step_ctrl #(
   parameter int DIV_W = 25,
   parameter int DB_W  = 16
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       run_sw,
   input  logic       step_btn,
   input  logic       ready_btn,
   input  logic       in_req,
   output logic       cpu_en,
   output logic       ready_out,
   output logic [1:0] mode,
   output logic       in_wait
);

   localparam logic [1:0] ST_HALT    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_STEP    = 2'd2;
   localparam logic [1:0] ST_WAIT_IN = 2'd3;

   localparam logic [DB_W-1:0]  DB_MAX  = '1;
   localparam logic [DIV_W-1:0] DIV_MAX = '1;

   // Bit 0 = run switch, bit 1 = step button, bit 2 = ready button.
   logic [2:0] raw_in;
   logic [2:0] db_lvl;

   assign raw_in = {ready_btn, step_btn, run_sw};

   // Per-input 2-flop synchronizer followed by a debouncer. The counter only
   // runs while the synced value disagrees with the debounced one, so any
   // bounce back to the old level restarts the stability window.
   for (genvar i = 0; i < 3; i++) begin : g_cond
      logic            s1;
      logic            s2;
      logic            lvl;
      logic [DB_W-1:0] cnt;

      always_ff @(posedge clk or negedge n_reset) begin
         if (!n_reset) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            lvl <= 1'b0;
            cnt <= '0;
         end else begin
            s1 <= raw_in[i];
            s2 <= s1;
            if (s2 == lvl) begin
               cnt <= '0;
            end else if (cnt == DB_MAX) begin
               lvl <= s2;
               cnt <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end

      assign db_lvl[i] = lvl;
   end

   logic run_db;
   logic step_db_d;
   logic ready_db_d;
   logic step_pulse;
   logic ready_pulse;

   assign run_db = db_lvl[0];

   // Registered rising-edge pulses for the two buttons.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         step_db_d   <= 1'b0;
         ready_db_d  <= 1'b0;
         step_pulse  <= 1'b0;
         ready_pulse <= 1'b0;
      end else begin
         step_db_d   <= db_lvl[1];
         ready_db_d  <= db_lvl[2];
         step_pulse  <= db_lvl[1] & ~step_db_d;
         ready_pulse <= db_lvl[2] & ~ready_db_d;
      end
   end

   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic [DIV_W-1:0] presc;
   logic             stall_req;

   // Once ready_out is set the CPU still holds in_req until it consumes the
   // data; masking with ready_out stops an immediate re-entry to WAIT_IN.
   assign stall_req = in_req & ~ready_out;

   always_comb begin
      state_nx = state;
      case (state)
         ST_HALT: begin
            if (stall_req)       state_nx = ST_WAIT_IN;
            else if (run_db)     state_nx = ST_RUN;
            else if (step_pulse) state_nx = ST_STEP;
         end
         ST_RUN: begin
            if (stall_req)       state_nx = ST_WAIT_IN;
            else if (!run_db)    state_nx = ST_HALT;
         end
         ST_STEP: begin
            state_nx = ST_HALT;
         end
         ST_WAIT_IN: begin
            if (ready_pulse)     state_nx = run_db ? ST_RUN : ST_HALT;
         end
         default: begin
            state_nx = ST_HALT;
         end
      endcase
   end

   // Outputs decode registered state only, so no input reaches them
   // combinationally and reset clears them without a clock edge.
   assign cpu_en  = (state == ST_STEP) | ((state == ST_RUN) & (presc == DIV_MAX));
   assign mode    = state;
   assign in_wait = (state == ST_WAIT_IN);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state     <= ST_HALT;
         presc     <= '0;
         ready_out <= 1'b0;
      end else begin
         state <= state_nx;

         // Restart the prescaler on entry so the first tick lands a full
         // period after entering RUN; it simply wraps while staying in RUN.
         if ((state_nx == ST_RUN) && (state != ST_RUN)) begin
            presc <= '0;
         end else if (state == ST_RUN) begin
            presc <= presc + 1'b1;
         end

         // Held until the CPU has taken one tick with it asserted.
         if ((state == ST_WAIT_IN) && ready_pulse) begin
            ready_out <= 1'b1;
         end else if (cpu_en) begin
            ready_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - self-checking bench for cpu_step_ctrl

module tb_cpu_step_ctrl;

   localparam int TB_DIV_W = 3;
   localparam int TB_DB_W  = 2;
   localparam int PERIOD   = 1 << TB_DIV_W;
   localparam int STABLE   = 1 << TB_DB_W;

   logic       clk = 1'b0;
   logic       n_reset;
   logic       run_sw;
   logic       step_btn;
   logic       ready_btn;
   logic       in_req;
   logic       cpu_en;
   logic       ready_out;
   logic [1:0] mode;
   logic       in_wait;

   int checks   = 0;
   int failures = 0;
   int en_seen  = 0;
   int step_seen = 0;

   cpu_step_ctrl #(
      .DIV_W(TB_DIV_W),
      .DB_W (TB_DB_W)
   ) dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .run_sw   (run_sw),
      .step_btn (step_btn),
      .ready_btn(ready_btn),
      .in_req   (in_req),
      .cpu_en   (cpu_en),
      .ready_out(ready_out),
      .mode     (mode),
      .in_wait  (in_wait)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: each button is an ideal level that is accepted once
   // its synced copy has disagreed with the accepted level for STABLE
   // consecutive samples; RUN ticks are counted by age since entry.
   int m_mode;
   int m_age;
   int m_run[3];
   bit m_ready;
   bit m_s1[3];
   bit m_s2[3];
   bit m_db[3];
   bit m_db_d[3];
   bit m_pulse[3];
   bit raw[3];

   function automatic bit m_en();
      return (m_mode == 2) || (m_mode == 1 && (m_age % PERIOD) == PERIOD - 1);
   endfunction

   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         m_mode  = 0;
         m_age   = 0;
         m_ready = 0;
         for (int i = 0; i < 3; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0;
            m_db_d[i] = 0; m_pulse[i] = 0; m_run[i] = 0;
         end
      end else begin : model_step
         bit en;
         bit stall;
         int nxt;
         en    = m_en();
         stall = in_req && !m_ready;
         nxt   = m_mode;
         case (m_mode)
            0: if (stall) nxt = 3; else if (m_db[0]) nxt = 1; else if (m_pulse[1]) nxt = 2;
            1: if (stall) nxt = 3; else if (!m_db[0]) nxt = 0;
            2: nxt = 0;
            default: if (m_pulse[2]) nxt = m_db[0] ? 1 : 0;
         endcase
         if (en) m_ready = 0;
         if (m_mode == 3 && m_pulse[2]) m_ready = 1;
         m_age  = (nxt == 1 && m_mode == 1) ? m_age + 1 : 0;
         m_mode = nxt;
         raw[0] = run_sw; raw[1] = step_btn; raw[2] = ready_btn;
         for (int i = 0; i < 3; i++) begin
            m_pulse[i] = m_db[i] && !m_db_d[i];
            m_db_d[i]  = m_db[i];
            if (m_s2[i] != m_db[i]) begin
               m_run[i]++;
               if (m_run[i] == STABLE) begin
                  m_db[i]  = m_s2[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = raw[i];
         end
      end
   end

   always @(negedge clk) begin
      chk("cpu_en",    int'(cpu_en),    int'(m_en()));
      chk("ready_out", int'(ready_out), int'(m_ready));
      chk("mode",      int'(mode),      m_mode);
      chk("in_wait",   int'(in_wait),   int'(m_mode == 3));
      if (cpu_en) en_seen++;
      if (mode == 2'd2) step_seen++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_mode(input int m, input int lim, input string nm);
      int n = 0;
      while (int'(mode) != m && n < lim) begin
         cyc(1);
         n++;
      end
      chk(nm, int'(mode), m);
   endtask

   task automatic async_reset_check(input string nm);
      @(posedge clk);
      #2;
      n_reset = 1'b0;
      #1;
      chk({nm, "_cpu_en"},    int'(cpu_en),    0);
      chk({nm, "_ready_out"}, int'(ready_out), 0);
      chk({nm, "_mode"},      int'(mode),      0);
      chk({nm, "_in_wait"},   int'(in_wait),   0);
   endtask

   initial begin
      int idx;
      n_reset = 1'b0; run_sw = 1'b0; step_btn = 1'b0; ready_btn = 1'b0; in_req = 1'b0;
      cyc(3);
      chk("reset_mode",   int'(mode),      0);
      chk("reset_cpu_en", int'(cpu_en),    0);
      chk("reset_ready",  int'(ready_out), 0);
      chk("reset_inwait", int'(in_wait),   0);
      n_reset = 1'b1;
      cyc(2);

      // Bounce rejection
      en_seen = 0;
      for (int i = 0; i < 10; i++) begin
         step_btn = ~step_btn;
         cyc(2);
      end
      step_btn = 1'b0;
      cyc(8);
      chk("bounce_en", en_seen, 0);
      chk("bounce_mode", int'(mode), 0);

      // Single step, twice
      for (int k = 0; k < 2; k++) begin
         en_seen = 0; step_seen = 0;
         step_btn = 1'b1;
         cyc(10);
         step_btn = 1'b0;
         cyc(12);
         chk("step_en_count", en_seen, 1);
         chk("step_mode_cycles", step_seen, 1);
         chk("step_back_halt", int'(mode), 0);
      end

      // Run
      run_sw = 1'b1;
      wait_mode(1, 30, "run_entry");
      idx = 1;
      while (!cpu_en && idx < 20) begin cyc(1); idx++; end
      chk("run_first_en", idx, 8);
      cyc(1);
      idx = 1;
      while (!cpu_en && idx < 20) begin cyc(1); idx++; end
      chk("run_period", idx, 8);
      run_sw = 1'b0;
      wait_mode(0, 30, "run_to_halt");
      cyc(10);

      // Input stall
      run_sw = 1'b1;
      wait_mode(1, 30, "stall_run_entry");
      cyc(3);
      in_req = 1'b1;
      wait_mode(3, 5, "stall_enter");
      chk("stall_in_wait", int'(in_wait), 1);
      en_seen = 0;
      cyc(100);
      chk("stall_no_en", en_seen, 0);
      ready_btn = 1'b1;
      wait_mode(1, 20, "stall_ready_run");
      chk("stall_ready_set", int'(ready_out), 1);
      ready_btn = 1'b0;
      idx = 0;
      while (!cpu_en && idx < 20) begin cyc(1); idx++; end
      chk("stall_tick_seen", int'(cpu_en), 1);
      chk("stall_ready_at_tick", int'(ready_out), 1);
      in_req = 1'b0;
      cyc(1);
      chk("stall_ready_clear", int'(ready_out), 0);
      chk("stall_no_reentry", int'(mode), 1);
      cyc(10);
      run_sw = 1'b0;
      wait_mode(0, 30, "stall_to_halt");
      cyc(10);

      // Priorities: coincident run and step edges
      step_seen = 0;
      run_sw = 1'b1; step_btn = 1'b1;
      cyc(20);
      chk("prio_no_step", step_seen, 0);
      chk("prio_run", int'(mode), 1);
      run_sw = 1'b0; step_btn = 1'b0;
      wait_mode(0, 30, "prio_halt");
      cyc(10);
      in_req = 1'b1;
      wait_mode(3, 5, "prio_in_req");
      en_seen = 0; step_seen = 0;
      step_btn = 1'b1;
      cyc(12);
      step_btn = 1'b0;
      cyc(10);
      chk("wait_step_ignored_mode", int'(mode), 3);
      chk("wait_step_ignored_en", en_seen, 0);

      // Reset mid-operation in WAIT_IN
      async_reset_check("rst_wait");
      cyc(2);
      n_reset = 1'b1;
      wait_mode(3, 5, "rst_wait_reenter");
      run_sw = 1'b1;
      cyc(12);
      chk("wait_ignores_run", int'(mode), 3);
      ready_btn = 1'b1;
      wait_mode(1, 20, "ready_to_run");
      chk("run_ready_set", int'(ready_out), 1);
      ready_btn = 1'b0;
      cyc(2);
      chk("run_ready_held", int'(ready_out), 1);

      // Reset mid-operation in RUN with ready_out pending
      async_reset_check("rst_run");
      in_req = 1'b0; run_sw = 1'b0;
      cyc(3);
      n_reset = 1'b1;
      cyc(10);
      chk("post_reset_halt", int'(mode), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Execution sequencer for the CPU core. Runs from the system clock and produces a single-cycle clock-enable tick (`cpu_en`) that advances the CPU. Three modes:
- free-running at a prescaled rate;
- single-step, one instruction per debounced button press;
- stalled on an input-port request until the operator confirms with a debounced `ready` button.

Sits between the board switches/buttons and the CPU's enable and `ready_in` pins, replacing the fixed divided clock.

## Interface
- `DIV_W`, default 25: prescaler width; in RUN, one `cpu_en` every 2^DIV_W cycles.
- `DB_W`, default 16: debounce counter width; an input must be stable for 2^DB_W cycles to register.
- `clk`  in  1  system clock; the block uses only this clock.
- `n_reset`  in  1  asynchronous active-low reset.
- `run_sw`  in  1  raw run switch. 1 selects RUN, 0 selects HALT.
- `step_btn`  in  1  raw single-step button, active-high.
- `ready_btn`  in  1  raw input-confirm button, active-high.
- `in_req`  in  1  from the CPU. High while it executes an IN instruction and needs data.
- `cpu_en`  out  1  single-cycle advance tick to the CPU.
- `ready_out`  out  1  to the CPU's `ready_in`. Says the input data is confirmed.
- `mode`  out  2  current state: HALT=0, RUN=1, STEP=2, WAIT_IN=3.
- `in_wait`  out  1  high in WAIT_IN, intended to drive an LED.

## Operation
- **Input conditioning.** Each raw input passes through a 2-flop synchronizer and then a debouncer.
  - The debouncer counter clears whenever the synced value equals the debounced value.
  - Otherwise the counter increments. When it reaches all-ones, the debounced value takes the synced value and the counter clears.
  - `step_btn` and `ready_btn` each produce a one-cycle registered pulse on the debounced rising edge.
  - `run_sw` is used as a debounced level, `run_db`.
- **State machine** (reset state HALT):
  - HALT:
    - if `in_req` & !`ready_out`, go to WAIT_IN;
    - else if `run_db`, go to RUN;
    - else if step pulse, go to STEP.
  - RUN:
    - the prescaler increments each cycle;
    - `cpu_en` = 1 in the cycle the prescaler is all-ones; the prescaler then wraps to 0;
    - if `in_req` & !`ready_out`, go to WAIT_IN;
    - else if !`run_db`, go to HALT.
  - STEP: `cpu_en` = 1 for this single cycle, then unconditionally go to HALT.
  - WAIT_IN:
    - `cpu_en` = 0; `run_db` and step pulses are ignored;
    - on a ready pulse, set `ready_out` and go to RUN if `run_db`, else HALT.
- **`ready_out` clearing.** `ready_out` stays set until the first `cpu_en` after it was set, and clears on the following edge. The CPU therefore samples it exactly once.
- **Prescaler.** Cleared to 0 on reset and on every entry to RUN. Held in all other states.
- **Ignored pulses.** A step pulse outside HALT is discarded. A ready pulse outside WAIT_IN is discarded. Neither is queued.
- **Output decoding.** `cpu_en`, `mode` and `in_wait` are decoded from registered state and the prescaler only, with no input-to-output combinational path.

## Timing
- **Reset values:** state HALT, `cpu_en` 0, `ready_out` 0, `mode` 0, `in_wait` 0, prescaler 0. All synchronizer, debounce and edge registers are 0.
- **Reset is asynchronous.** Asserting it mid-RUN or in WAIT_IN forces these values immediately, so any pending `ready_out` is lost.
- **Button latency.** A raw change at edge 0, held stable, reaches the synced output after 2 edges. The debounced value changes 2^DB_W edges later. The pulse is high on the next cycle, and the state changes on the edge after that.
- **STEP:** `cpu_en` is high for exactly 1 cycle per accepted step pulse.
- **RUN:** the first `cpu_en` comes in the 2^DIV_W-th cycle after entry, then one every 2^DIV_W cycles.
- **Simultaneous events:**
  - in HALT, a step pulse together with `run_db`=1 goes to RUN; the step is dropped;
  - `in_req` takes priority over both.
- **Re-entry guard.** `in_req` still high while `ready_out`=1 does not re-enter WAIT_IN. The CPU drops `in_req` after the consuming tick.

## Test plan
Parameters for all cases: DB_W=2, DIV_W=3.
- **Reset / bounce rejection:** hold `n_reset` low, then release; toggle `step_btn` every 2 cycles for 20 cycles -> `mode`=0, `cpu_en` never high.
- **Single step:** hold `step_btn` high 10 cycles -> exactly one `cpu_en` pulse, `mode` sequence 0 -> 2 -> 0. Release and press again -> a second single pulse.
- **Run:** hold `run_sw`=1 -> `mode`=1. `cpu_en` pulses every 8 cycles, the first on the 8th RUN cycle. Set `run_sw`=0 -> HALT; `cpu_en` stops within 7 cycles of the debounced change.
- **Input stall:** in RUN, raise `in_req` -> `mode`=3, `in_wait`=1, `cpu_en` low for 100 cycles. Press `ready_btn` -> RUN, `ready_out`=1 until 1 cycle after the next `cpu_en`. Drop `in_req` at that tick -> no re-entry to WAIT_IN.
- **Priorities:** in HALT, make the step and run debounced edges coincide -> RUN, no STEP cycle. Assert `in_req` in HALT -> WAIT_IN; step presses there are ignored.
- **Reset mid-operation:** assert `n_reset` in WAIT_IN and separately in RUN with `ready_out`=1 -> all outputs 0 immediately, asynchronously, without waiting for a clock edge.
